// File: rtl/pll_startup_sequencer.sv
// pll_startup_sequencer: timed AFC reset/start/calibrate, then PLL enable and lock qualification with retries.
// Optional feature macro PLL_SEQ_RELOCK_EN: lock loss in LOCKED resequences instead of failing.
module pll_startup_sequencer #(
  parameter int RST_CYCLES  = 4000,
  parameter int START_DELAY = 5,
  parameter int START_PULSE = 50,
  parameter int TIMEOUT     = 4096,
  parameter int LOCK_QUAL   = 256,
  parameter int MAX_RETRY   = 3,
  parameter int CNT_W       = 16
) (
  input  logic       clk40,
  input  logic       rstn,
  input  logic       enable,
  input  logic       afc_bypass,
  input  logic [5:0] override_cap,
  input  logic       INSTLOCK_PLL,
  input  logic       toI2C_AFCbusy,
  input  logic [5:0] toI2C_AFCcalCap,
  output logic       toAFC_RST,
  output logic       toAFC_Start,
  output logic       toAFC_OverrideCtrl,
  output logic [5:0] toAFC_OverrideCtrl_val1,
  output logic       topll_ENABLEPLL,
  output logic       topll_overrideVc,
  output logic [2:0] state,
  output logic       locked,
  output logic       fail,
  output logic [1:0] retry_cnt,
  output logic [5:0] cal_cap
);
  typedef enum logic [2:0] {
    S_IDLE, S_AFC_RST, S_AFC_START, S_AFC_WAIT, S_PLL_EN, S_LOCK_WAIT, S_LOCKED, S_FAIL
  } state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] timer_q, qual_q;
  logic lock_m_q, lock_s, busy_m_q, busy_s, busy_seen_q;
  logic retry, retry_last, cap_load;
  logic [5:0] cap_src;
  assign state      = state_q;
  assign retry_last = ({1'b0, retry_cnt} + 3'd1) == 3'(MAX_RETRY);
  assign cap_load   = state_d == S_PLL_EN && state_q != S_PLL_EN;
  assign cap_src    = state_q == S_AFC_RST ? override_cap : toI2C_AFCcalCap;
  always_comb begin
    state_d = state_q;
    retry   = 1'b0;
    case (state_q)
      S_IDLE:      state_d = enable ? S_AFC_RST : S_IDLE;
      S_AFC_RST:   if (timer_q == CNT_W'(RST_CYCLES + START_DELAY - 1))
                     state_d = afc_bypass ? S_PLL_EN : S_AFC_START;
      S_AFC_START: if (timer_q == CNT_W'(START_PULSE - 1)) state_d = S_AFC_WAIT;
      S_AFC_WAIT:  if (busy_seen_q && !busy_s) state_d = S_PLL_EN;
                   else retry = timer_q == CNT_W'(TIMEOUT - 1);
      S_PLL_EN:    state_d = S_LOCK_WAIT;
      S_LOCK_WAIT: if (qual_q >= CNT_W'(LOCK_QUAL)) state_d = S_LOCKED;
                   else retry = timer_q == CNT_W'(TIMEOUT - 1);
`ifdef PLL_SEQ_RELOCK_EN
      S_LOCKED:    retry = !lock_s;
`else
      S_LOCKED:    if (!lock_s) state_d = S_FAIL;
`endif
      S_FAIL:      state_d = S_FAIL;
    endcase
    if (retry) state_d = retry_last ? S_FAIL : S_AFC_RST;
    if (!enable) begin
      state_d = S_IDLE;
      retry   = 1'b0;
    end
  end
  // Outputs are registered from the next state, so they change on the same edge as the state.
  always_ff @(posedge clk40) begin
    if (!rstn) begin
      state_q                 <= S_IDLE;
      timer_q                 <= '0;
      qual_q                  <= '0;
      {lock_m_q, lock_s}      <= 2'b00;
      {busy_m_q, busy_s}      <= 2'b00;
      busy_seen_q             <= 1'b0;
      toAFC_RST               <= 1'b1;
      toAFC_Start             <= 1'b0;
      toAFC_OverrideCtrl      <= 1'b1;
      toAFC_OverrideCtrl_val1 <= 6'd0;
      topll_ENABLEPLL         <= 1'b0;
      topll_overrideVc        <= 1'b1;
      locked                  <= 1'b0;
      fail                    <= 1'b0;
      retry_cnt               <= 2'd0;
      cal_cap                 <= 6'd0;
    end else begin
      state_q                 <= state_d;
      {lock_m_q, lock_s}      <= {INSTLOCK_PLL, lock_m_q};
      {busy_m_q, busy_s}      <= {toI2C_AFCbusy, busy_m_q};
      timer_q                 <= (state_d != state_q || state_d inside {S_IDLE, S_LOCKED, S_FAIL}) ? '0 : timer_q + 1'b1;
      qual_q                  <= (state_q == S_LOCK_WAIT && state_d == S_LOCK_WAIT && lock_s) ? qual_q + 1'b1 : '0;
      busy_seen_q             <= (state_q inside {S_AFC_START, S_AFC_WAIT} && state_d inside {S_AFC_START, S_AFC_WAIT})
                                 ? busy_seen_q | busy_s : 1'b0;
      toAFC_RST               <= state_d inside {S_IDLE, S_FAIL} ||
                                 (state_d == S_AFC_RST && !(state_q == S_AFC_RST && timer_q >= CNT_W'(RST_CYCLES - 1)));
      toAFC_Start             <= state_d == S_AFC_START;
      toAFC_OverrideCtrl      <= !(state_d inside {S_AFC_START, S_AFC_WAIT});
      toAFC_OverrideCtrl_val1 <= cap_load ? cap_src : state_d inside {S_IDLE, S_AFC_RST} ? 6'd0 : toAFC_OverrideCtrl_val1;
      cal_cap                 <= cap_load ? cap_src : cal_cap;
      topll_ENABLEPLL         <= state_d inside {S_PLL_EN, S_LOCK_WAIT, S_LOCKED};
      topll_overrideVc        <= !(state_d inside {S_PLL_EN, S_LOCK_WAIT, S_LOCKED});
      locked                  <= state_d == S_LOCKED;
      fail                    <= state_d == S_FAIL;
      retry_cnt               <= (state_q == S_IDLE && state_d == S_AFC_RST) ? 2'd0 :
                                 retry ? (retry_last ? 2'(MAX_RETRY) : retry_cnt + 2'd1) : retry_cnt;
    end
  end
endmodule

// File: tb/tb_pll_startup_sequencer.sv
// tb_pll_startup_sequencer: directed scenarios for the PLL start-up sequencer with small timing parameters.
module tb_pll_startup_sequencer;
  logic clk40 = 1'b0, rstn = 1'b0, enable = 1'b0, afc_bypass = 1'b0;
  logic INSTLOCK_PLL = 1'b0, toI2C_AFCbusy = 1'b0;
  logic [5:0] override_cap = 6'd0, toI2C_AFCcalCap = 6'd0;
  logic toAFC_RST, toAFC_Start, toAFC_OverrideCtrl, topll_ENABLEPLL, topll_overrideVc, locked, fail;
  logic [5:0] toAFC_OverrideCtrl_val1, cal_cap;
  logic [2:0] state;
  logic [1:0] retry_cnt;
  int checks = 0, errors = 0;
  always #5 clk40 = ~clk40;
  pll_startup_sequencer #(
    .RST_CYCLES(8), .START_DELAY(2), .START_PULSE(4), .TIMEOUT(64),
    .LOCK_QUAL(16), .MAX_RETRY(3), .CNT_W(16)
  ) dut (
    .clk40(clk40), .rstn(rstn), .enable(enable), .afc_bypass(afc_bypass),
    .override_cap(override_cap), .INSTLOCK_PLL(INSTLOCK_PLL), .toI2C_AFCbusy(toI2C_AFCbusy),
    .toI2C_AFCcalCap(toI2C_AFCcalCap), .toAFC_RST(toAFC_RST), .toAFC_Start(toAFC_Start),
    .toAFC_OverrideCtrl(toAFC_OverrideCtrl), .toAFC_OverrideCtrl_val1(toAFC_OverrideCtrl_val1),
    .topll_ENABLEPLL(topll_ENABLEPLL), .topll_overrideVc(topll_overrideVc), .state(state),
    .locked(locked), .fail(fail), .retry_cnt(retry_cnt), .cal_cap(cal_cap)
  );
  // {state, RST, Start, OvrCtrl, val1, ENABLEPLL, overrideVc, locked, fail, retry_cnt, cal_cap}
  function automatic logic [23:0] outs();
    return {state, toAFC_RST, toAFC_Start, toAFC_OverrideCtrl, toAFC_OverrideCtrl_val1,
            topll_ENABLEPLL, topll_overrideVc, locked, fail, retry_cnt, cal_cap};
  endfunction
  function automatic logic [23:0] idle_vec(input logic [1:0] r, input logic [5:0] c);
    return {3'd0, 1'b1, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, c};
  endfunction
  task automatic tick(input int n);
    repeat (n) @(posedge clk40);
    #1;
  endtask
  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick(1);
      ok = state === s;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1;
    tick(3);
    checks++; if (outs() !== idle_vec(2'd0, 6'd0)) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", outs(), idle_vec(2'd0, 6'd0)); end
    enable = 1'b0; rstn = 1'b1;
    tick(2);
    checks++; if (outs() !== idle_vec(2'd0, 6'd0)) begin errors++; $display("FAIL idle_outputs got=%h exp=%h", outs(), idle_vec(2'd0, 6'd0)); end
  endtask

  task automatic test_start_timing();
    logic [2:0] es;
    logic er, est;
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      es = k < 11 ? 3'd1 : k < 15 ? 3'd2 : 3'd3;
      er = k < 9;
      est = k >= 11 && k <= 14;
      checks++; if (state !== es) begin errors++; $display("FAIL seq_state cyc=%0d got=%0d exp=%0d", k, state, es); end
      checks++; if (toAFC_RST !== er) begin errors++; $display("FAIL afc_rst cyc=%0d got=%b exp=%b", k, toAFC_RST, er); end
      checks++; if (toAFC_Start !== est) begin errors++; $display("FAIL afc_start cyc=%0d got=%b exp=%b", k, toAFC_Start, est); end
    end
  endtask

  task automatic test_afc_lock();
    INSTLOCK_PLL = 1'b1; toI2C_AFCcalCap = 6'h3F; toI2C_AFCbusy = 1'b1;
    tick(20);
    toI2C_AFCbusy = 1'b0; toI2C_AFCcalCap = 6'h2A;
    tick(2);
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL afc_wait_hold got=%0d exp=3", state); end
    tick(1);
    checks++; if (state !== 3'd4) begin errors++; $display("FAIL pll_en_state got=%0d exp=4", state); end
    checks++; if ({topll_ENABLEPLL, topll_overrideVc} !== 2'b10) begin errors++; $display("FAIL pll_en_ctrl got=%b exp=10", {topll_ENABLEPLL, topll_overrideVc}); end
    checks++; if ({toAFC_OverrideCtrl, toAFC_OverrideCtrl_val1, cal_cap} !== {1'b1, 6'h2A, 6'h2A}) begin errors++; $display("FAIL cap_frozen got ovr=%b val1=%h cal=%h exp 1/2a/2a", toAFC_OverrideCtrl, toAFC_OverrideCtrl_val1, cal_cap); end
    tick(1);
    checks++; if (state !== 3'd5) begin errors++; $display("FAIL lock_wait_state got=%0d exp=5", state); end
    tick(16);
    checks++; if ({state, locked} !== {3'd5, 1'b0}) begin errors++; $display("FAIL qual_early got state=%0d locked=%b exp 5/0", state, locked); end
    tick(1);
    checks++; if ({state, locked, fail, retry_cnt} !== {3'd6, 1'b1, 1'b0, 2'd0}) begin errors++; $display("FAIL locked got state=%0d locked=%b fail=%b retry=%0d exp 6/1/0/0", state, locked, fail, retry_cnt); end
    checks++; if ({toAFC_OverrideCtrl_val1, cal_cap, toAFC_OverrideCtrl} !== {6'h2A, 6'h2A, 1'b1}) begin errors++; $display("FAIL locked_cap got val1=%h cal=%h ovr=%b exp 2a/2a/1", toAFC_OverrideCtrl_val1, cal_cap, toAFC_OverrideCtrl); end
  endtask

  task automatic test_lock_loss(output logic [1:0] r);
    bit ok;
    INSTLOCK_PLL = 1'b0;
    tick(2);
    checks++; if (state !== 3'd6) begin errors++; $display("FAIL loss_sync got=%0d exp=6", state); end
    tick(1);
`ifdef PLL_SEQ_RELOCK_EN
    checks++; if ({state, locked, retry_cnt, toAFC_RST, topll_ENABLEPLL} !== {3'd1, 1'b0, 2'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL relock_retry got state=%0d locked=%b retry=%0d rst=%b en=%b", state, locked, retry_cnt, toAFC_RST, topll_ENABLEPLL); end
    tick(2);
    INSTLOCK_PLL = 1'b1;
    wait_state(3'd3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL relock_afc_wait timeout state=%0d exp=3", state); end
    toI2C_AFCbusy = 1'b1;
    tick(5);
    toI2C_AFCbusy = 1'b0;
    wait_state(3'd6, 100, ok);
    checks++; if (!ok || retry_cnt !== 2'd1 || locked !== 1'b1) begin errors++; $display("FAIL relock_done state=%0d retry=%0d locked=%b exp 6/1/1", state, retry_cnt, locked); end
    r = 2'd1;
`else
    checks++; if ({state, fail, locked, topll_ENABLEPLL, toAFC_RST, retry_cnt} !== {3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0}) begin errors++; $display("FAIL loss_fail got state=%0d fail=%b locked=%b en=%b rst=%b retry=%0d", state, fail, locked, topll_ENABLEPLL, toAFC_RST, retry_cnt); end
    tick(2);
    INSTLOCK_PLL = 1'b1;
    tick(5);
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL fail_sticky got=%0d exp=7", state); end
    r = 2'd0;
`endif
  endtask

  task automatic test_disable_readback(input logic [1:0] r);
    enable = 1'b0;
    tick(1);
    checks++; if (outs() !== idle_vec(r, 6'h2A)) begin errors++; $display("FAIL disable_readback got=%h exp=%h", outs(), idle_vec(r, 6'h2A)); end
  endtask

  task automatic test_retry_fail();
    int entries = 0;
    logic [2:0] prev = 3'd0;
    INSTLOCK_PLL = 1'b0; toI2C_AFCbusy = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 1000 && state !== 3'd7; i++) begin
      tick(1);
      if (state === 3'd1 && prev !== 3'd1) entries++;
      prev = state;
    end
    checks++; if (entries != 3) begin errors++; $display("FAIL retry_entries got=%0d exp=3", entries); end
    checks++; if ({state, fail, retry_cnt, toAFC_RST, topll_ENABLEPLL} !== {3'd7, 1'b1, 2'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL retry_fail got state=%0d fail=%b retry=%0d rst=%b en=%b", state, fail, retry_cnt, toAFC_RST, topll_ENABLEPLL); end
    tick(5);
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL retry_hold got=%0d exp=7", state); end
    enable = 1'b0;
    tick(1);
    checks++; if ({state, fail, retry_cnt, toAFC_RST} !== {3'd0, 1'b0, 2'd3, 1'b1}) begin errors++; $display("FAIL fail_exit got state=%0d fail=%b retry=%0d rst=%b exp 0/0/3/1", state, fail, retry_cnt, toAFC_RST); end
  endtask

  task automatic test_bypass();
    logic saw_start = 1'b0;
    afc_bypass = 1'b1; override_cap = 6'h11; INSTLOCK_PLL = 1'b0;
    enable = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      saw_start |= toAFC_Start;
      if (k == 10) begin
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL bypass_pre got=%0d exp=1", state); end
      end
    end
    checks++; if (saw_start !== 1'b0) begin errors++; $display("FAIL bypass_start got=%b exp=0", saw_start); end
    checks++; if ({state, toAFC_OverrideCtrl, toAFC_OverrideCtrl_val1, cal_cap, topll_ENABLEPLL, topll_overrideVc} !== {3'd4, 1'b1, 6'h11, 6'h11, 1'b1, 1'b0}) begin errors++; $display("FAIL bypass_pll_en got state=%0d ovr=%b val1=%h cal=%h en=%b vc=%b", state, toAFC_OverrideCtrl, toAFC_OverrideCtrl_val1, cal_cap, topll_ENABLEPLL, topll_overrideVc); end
    tick(1);
    INSTLOCK_PLL = 1'b1;
    tick(18);
    checks++; if ({state, locked} !== {3'd5, 1'b0}) begin errors++; $display("FAIL lock_lat_early got state=%0d locked=%b exp 5/0", state, locked); end
    tick(1);
    checks++; if ({state, locked} !== {3'd6, 1'b1}) begin errors++; $display("FAIL lock_lat got state=%0d locked=%b exp 6/1", state, locked); end
    enable = 1'b0;
    tick(1);
  endtask

  task automatic test_abort();
    bit ok;
    INSTLOCK_PLL = 1'b0; afc_bypass = 1'b1;
    enable = 1'b1;
    wait_state(3'd5, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach_lockwait state=%0d exp=5", state); end
    enable = 1'b0;
    tick(1);
    checks++; if (outs() !== idle_vec(2'd0, 6'h11)) begin errors++; $display("FAIL abort_enable got=%h exp=%h", outs(), idle_vec(2'd0, 6'h11)); end
    afc_bypass = 1'b0;
    enable = 1'b1;
    wait_state(3'd3, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach_afcwait state=%0d exp=3", state); end
    rstn = 1'b0;
    tick(1);
    checks++; if (outs() !== idle_vec(2'd0, 6'd0)) begin errors++; $display("FAIL abort_rstn got=%h exp=%h", outs(), idle_vec(2'd0, 6'd0)); end
    rstn = 1'b1; enable = 1'b0;
    tick(1);
  endtask

  initial begin
    logic [1:0] r;
    test_reset();
    test_start_timing();
    test_afc_lock();
    test_lock_loss(r);
    test_disable_readback(r);
    test_retry_fail();
    test_bypass();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
